imem_fetch: RTL

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/imem_fetch.sv
// Instruction memory with a one-deep response register: accepts one fetch per cycle,
// flags misaligned/out-of-range PCs, supports flush and program-load writes.
module imem_fetch #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 1024,
   parameter int                ADDR_W    = 32,
   parameter int                BYTE_ADDR = 1,
   parameter logic [DATA_W-1:0] NOP_WORD  = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ADDR_W-1:0]          req_pc,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_W-1:0]          rsp_ir,
   output logic [1:0]                 rsp_fault,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   output logic [15:0]                fetch_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_ir_q, rsp_ir_d;
   logic [1:0]        rsp_fault_q, rsp_fault_d;
   logic [15:0]       cnt_q, cnt_d;

   logic [ADDR_W-1:0] widx_full;
   logic [AW-1:0]     widx;
   logic [1:0]        fault;
   logic              accept;

   assign req_ready = !flush && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;

   // Range check uses the whole derived index so high PC bits cannot alias into the array.
   always_comb begin
      widx_full = (BYTE_ADDR != 0) ? (req_pc >> 2) : req_pc;
      widx      = widx_full[AW-1:0];
      fault     = 2'b00;
      if ((BYTE_ADDR != 0) && (req_pc[1:0] != 2'b00)) begin
         fault = 2'b01;
      end else if ((widx_full >> AW) != '0) begin
         fault = 2'b10;
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_ir_d    = rsp_ir_q;
      rsp_fault_d = rsp_fault_q;
      cnt_d       = cnt_q;
      if (flush) begin
         rsp_valid_d = 1'b0;
      end else if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_fault_d = fault;
         rsp_ir_d    = (fault != 2'b00) ? NOP_WORD : mem_q[widx];
         if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_ir_q    <= '0;
         rsp_fault_q <= 2'b00;
         cnt_q       <= 16'd0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_ir_q    <= rsp_ir_d;
         rsp_fault_q <= rsp_fault_d;
         cnt_q       <= cnt_d;
      end
   end

   // Memory is deliberately outside the reset domain; the read above sees the pre-write value.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_ir    = rsp_ir_q;
   assign rsp_fault = rsp_fault_q;
   assign fetch_cnt = cnt_q;

endmodule
